// File: rtl/conv_engine.sv
// Multi-channel 2-D convolution engine: one MAC tap per cycle over a 1-cycle-latency
// ifmap read port, bias + requantise + ReLU/saturate, valid/ready pixel stream out.
module conv_engine #(
    parameter int DATA_WIDTH  = 8,
    parameter int IFMAP_SIZE  = 8,
    parameter int KERNEL_SIZE = 3,
    parameter int IN_CH       = 1,
    parameter int STRIDE      = 1,
    parameter int PADDING     = 0,
    parameter int ACC_WIDTH   = 24,
    parameter int OUT_SHIFT   = 0,
    parameter int RELU_EN     = 1,
    localparam int OFMAP_SIZE = (IFMAP_SIZE + 2*PADDING - KERNEL_SIZE) / STRIDE + 1,
    localparam int ADDR_W     = (IN_CH*IFMAP_SIZE*IFMAP_SIZE > 1) ? $clog2(IN_CH*IFMAP_SIZE*IFMAP_SIZE) : 1,
    localparam int RC_W       = (OFMAP_SIZE > 1) ? $clog2(OFMAP_SIZE) : 1
) (
    input  logic                                         clk,
    input  logic                                         reset,
    input  logic                                         start,
    input  logic [IN_CH*KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] weights,
    input  logic signed [ACC_WIDTH-1:0]                  bias,
    output logic                                         busy,
    output logic                                         done,
    output logic                                         ifm_rd_en,
    output logic [ADDR_W-1:0]                            ifm_rd_addr,
    input  logic [DATA_WIDTH-1:0]                        ifm_rd_data,
    output logic                                         ofm_valid,
    input  logic                                         ofm_ready,
    output logic [DATA_WIDTH-1:0]                        ofm_data,
    output logic [RC_W-1:0]                              ofm_row,
    output logic [RC_W-1:0]                              ofm_col
);

    localparam int C_W = (IN_CH > 1) ? $clog2(IN_CH) : 1;
    localparam int K_W = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
    localparam logic signed [ACC_WIDTH-1:0] UMAX = ACC_WIDTH'((64'd1 << DATA_WIDTH) - 64'd1);
    localparam logic signed [ACC_WIDTH-1:0] SMAX = ACC_WIDTH'((64'd1 << (DATA_WIDTH-1)) - 64'd1);
    localparam logic signed [ACC_WIDTH-1:0] SMIN = ~SMAX;

    typedef enum logic [2:0] {S_IDLE, S_MAC, S_DRAIN, S_OUT, S_DONE} state_t;

    state_t                         state;
    logic [C_W-1:0]                 ch;
    logic [K_W-1:0]                 ki, kj;
    logic [RC_W-1:0]                row, col;
    logic signed [ACC_WIDTH-1:0]    acc;
    logic                           pend;
    logic signed [DATA_WIDTH-1:0]   pend_w;

    int                             tr, tc, tap;
    logic                           in_range;
    logic signed [DATA_WIDTH-1:0]   tap_w;
    logic signed [2*DATA_WIDTH:0]   prod;
    logic signed [ACC_WIDTH-1:0]    acc_sum, q;
    logic [DATA_WIDTH-1:0]          sat;

    always_comb begin
        tr       = int'(row) * STRIDE + int'(ki) - PADDING;
        tc       = int'(col) * STRIDE + int'(kj) - PADDING;
        tap      = (int'(ch) * KERNEL_SIZE + int'(ki)) * KERNEL_SIZE + int'(kj);
        in_range = (tr >= 0) && (tr < IFMAP_SIZE) && (tc >= 0) && (tc < IFMAP_SIZE);
        tap_w    = weights[tap*DATA_WIDTH +: DATA_WIDTH];
        ifm_rd_en   = (state == S_MAC) && in_range;
        ifm_rd_addr = ifm_rd_en ? ADDR_W'(int'(ch)*IFMAP_SIZE*IFMAP_SIZE + tr*IFMAP_SIZE + tc) : '0;
    end

    // Read data arrives one cycle after the tap; pend/pend_w carry that tap's weight forward.
    always_comb begin
        prod    = (2*DATA_WIDTH+1)'($signed({1'b0, ifm_rd_data})) * (2*DATA_WIDTH+1)'(pend_w);
        acc_sum = pend ? acc + ACC_WIDTH'(prod) : acc;
        q       = acc_sum >>> OUT_SHIFT;
        sat     = q[DATA_WIDTH-1:0];
        if (RELU_EN != 0) begin
            if (q < 0)         sat = '0;
            else if (q > UMAX) sat = '1;
        end else begin
            if (q > SMAX)      sat = SMAX[DATA_WIDTH-1:0];
            else if (q < SMIN) sat = SMIN[DATA_WIDTH-1:0];
        end
    end

    assign busy      = (state != S_IDLE);
    assign ofm_valid = (state == S_OUT);
    assign done      = (state == S_DONE);
    assign ofm_row   = row;
    assign ofm_col   = col;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            ch       <= '0;
            ki       <= '0;
            kj       <= '0;
            row      <= '0;
            col      <= '0;
            acc      <= '0;
            pend     <= 1'b0;
            pend_w   <= '0;
            ofm_data <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_MAC;
                        ch    <= '0;
                        ki    <= '0;
                        kj    <= '0;
                        row   <= '0;
                        col   <= '0;
                        acc   <= bias;
                        pend  <= 1'b0;
                    end
                end
                S_MAC: begin
                    pend   <= in_range;
                    pend_w <= tap_w;
                    acc    <= acc_sum;
                    if (kj == K_W'(KERNEL_SIZE-1)) begin
                        kj <= '0;
                        if (ki == K_W'(KERNEL_SIZE-1)) begin
                            ki <= '0;
                            if (ch == C_W'(IN_CH-1)) begin
                                ch    <= '0;
                                state <= S_DRAIN;
                            end else begin
                                ch <= ch + C_W'(1);
                            end
                        end else begin
                            ki <= ki + K_W'(1);
                        end
                    end else begin
                        kj <= kj + K_W'(1);
                    end
                end
                S_DRAIN: begin
                    acc      <= acc_sum;
                    pend     <= 1'b0;
                    ofm_data <= sat;
                    state    <= S_OUT;
                end
                S_OUT: begin
                    if (ofm_ready) begin
                        if (row == RC_W'(OFMAP_SIZE-1) && col == RC_W'(OFMAP_SIZE-1)) begin
                            row   <= '0;
                            col   <= '0;
                            state <= S_DONE;
                        end else begin
                            if (col == RC_W'(OFMAP_SIZE-1)) begin
                                col <= '0;
                                row <= row + RC_W'(1);
                            end else begin
                                col <= col + RC_W'(1);
                            end
                            acc   <= bias;
                            state <= S_MAC;
                        end
                    end
                end
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_engine.sv
// Randomised bench for conv_engine: two configurations checked against a plain
// arithmetic convolution model, with backpressure, saturation and mid-run reset.
module tb_conv_engine;
    localparam int DW   = 8;
    localparam int AW   = 24;
    localparam int KS   = 3;
    localparam int IFS[2] = '{5, 4};
    localparam int ICS[2] = '{2, 1};
    localparam int STS[2] = '{2, 1};
    localparam int PDS[2] = '{1, 0};
    localparam int SHS[2] = '{1, 0};
    localparam int RLS[2] = '{1, 0};
    localparam int RND  = 1000;
    localparam int RNDS = 1001;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic                    start[2];
    logic                    ready[2];
    logic [DW-1:0]           rd_data[2];
    logic [2*KS*KS*DW-1:0]   wts[2];
    logic signed [AW-1:0]    bias[2];

    logic busy[2], done[2], rd_en[2], valid[2];
    logic [5:0] rd_addr[2];
    logic [DW-1:0] odata[2];
    logic [1:0] orow[2], ocol[2];

    logic a_busy, a_done, a_rd_en, a_valid, b_busy, b_done, b_rd_en, b_valid;
    logic [5:0] a_addr;
    logic [3:0] b_addr;
    logic [DW-1:0] a_data, b_data;
    logic [1:0] a_row, a_col;
    logic [0:0] b_row, b_col;

    logic [DW-1:0] mem[2][64];
    int            wt[2][18];
    int            total = 0;
    int            bad = 0;

    conv_engine #(.DATA_WIDTH(DW), .IFMAP_SIZE(5), .KERNEL_SIZE(KS), .IN_CH(2), .STRIDE(2),
                  .PADDING(1), .ACC_WIDTH(AW), .OUT_SHIFT(1), .RELU_EN(1)) dut_a (
        .clk(clk), .reset(reset), .start(start[0]), .weights(wts[0]), .bias(bias[0]),
        .busy(a_busy), .done(a_done), .ifm_rd_en(a_rd_en), .ifm_rd_addr(a_addr),
        .ifm_rd_data(rd_data[0]), .ofm_valid(a_valid), .ofm_ready(ready[0]),
        .ofm_data(a_data), .ofm_row(a_row), .ofm_col(a_col));

    conv_engine #(.DATA_WIDTH(DW), .IFMAP_SIZE(4), .KERNEL_SIZE(KS), .IN_CH(1), .STRIDE(1),
                  .PADDING(0), .ACC_WIDTH(AW), .OUT_SHIFT(0), .RELU_EN(0)) dut_b (
        .clk(clk), .reset(reset), .start(start[1]), .weights(wts[1][KS*KS*DW-1:0]), .bias(bias[1]),
        .busy(b_busy), .done(b_done), .ifm_rd_en(b_rd_en), .ifm_rd_addr(b_addr),
        .ifm_rd_data(rd_data[1]), .ofm_valid(b_valid), .ofm_ready(ready[1]),
        .ofm_data(b_data), .ofm_row(b_row), .ofm_col(b_col));

    always_comb begin
        busy[0] = a_busy;  done[0] = a_done;  rd_en[0] = a_rd_en;  valid[0] = a_valid;
        busy[1] = b_busy;  done[1] = b_done;  rd_en[1] = b_rd_en;  valid[1] = b_valid;
        rd_addr[0] = a_addr;          rd_addr[1] = {2'b00, b_addr};
        odata[0] = a_data;            odata[1] = b_data;
        orow[0] = a_row;              orow[1] = {1'b0, b_row};
        ocol[0] = a_col;              ocol[1] = {1'b0, b_col};
    end

    // Memory with 1-cycle read latency; idle cycles return junk so padded taps must not use it.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++)
            rd_data[d] <= rd_en[d] ? mem[d][rd_addr[d]] : DW'($urandom);
    end

    task automatic chk(input string tag, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic string tg(input string s, input int d);
        return $sformatf("%s_%0d", s, d);
    endfunction

    function automatic int of_sz(input int d);
        return (IFS[d] + 2*PDS[d] - KS) / STS[d] + 1;
    endfunction

    function automatic bit tap_ok(input int d, input int r, input int c, input int i, input int j);
        int tr, tc;
        tr = r*STS[d] + i - PDS[d];
        tc = c*STS[d] + j - PDS[d];
        return tr >= 0 && tr < IFS[d] && tc >= 0 && tc < IFS[d];
    endfunction

    function automatic int ref_taps(input int d, input int r, input int c);
        int n = 0;
        for (int ch = 0; ch < ICS[d]; ch++)
            for (int i = 0; i < KS; i++)
                for (int j = 0; j < KS; j++)
                    if (tap_ok(d, r, c, i, j)) n++;
        return n;
    endfunction

    function automatic logic [DW-1:0] ref_pix(input int d, input int r, input int c);
        int acc, q, n;
        n = IFS[d];
        acc = int'(bias[d]);
        for (int ch = 0; ch < ICS[d]; ch++)
            for (int i = 0; i < KS; i++)
                for (int j = 0; j < KS; j++)
                    if (tap_ok(d, r, c, i, j))
                        acc += int'(mem[d][ch*n*n + (r*STS[d]+i-PDS[d])*n + (c*STS[d]+j-PDS[d])])
                               * wt[d][(ch*KS+i)*KS+j];
        q = acc >>> SHS[d];
        if (RLS[d] != 0) q = (q < 0) ? 0 : ((q > 255) ? 255 : q);
        else             q = (q < -128) ? -128 : ((q > 127) ? 127 : q);
        return q[DW-1:0];
    endfunction

    task automatic load(input int d, input int p0, input int p1, input int w, input int b);
        int n, v;
        n = IFS[d]*IFS[d];
        for (int ch = 0; ch < ICS[d]; ch++)
            for (int a = 0; a < n; a++) begin
                v = (ch == 0) ? p0 : p1;
                if (v == RND)       mem[d][ch*n+a] = DW'($urandom_range(0, 255));
                else if (v == RNDS) mem[d][ch*n+a] = DW'($urandom_range(0, 7));
                else                mem[d][ch*n+a] = DW'(v);
            end
        for (int t = 0; t < ICS[d]*KS*KS; t++) begin
            if (w == RND)       wt[d][t] = int'($urandom_range(0, 255)) - 128;
            else if (w == RNDS) wt[d][t] = int'($urandom_range(0, 8)) - 4;
            else                wt[d][t] = w;
            wts[d][t*DW +: DW] = DW'(wt[d][t]);
        end
        if (b == RND || b == RNDS) bias[d] = AW'(int'($urandom_range(0, 127)) - 64);
        else                       bias[d] = AW'(b);
    endtask

    task automatic chk_idle(input int d, input string name);
        chk(tg(name, d), {busy[d], done[d], rd_en[d], valid[d], odata[d], orow[d], ocol[d], rd_addr[d]}, 0);
    endtask

    // mode 0: ready always high; 1: random ready; 2: 5-cycle stall on pixel (0,1)
    task automatic run_frame(input int d, input int mode, output logic [DW-1:0] last_data);
        int of, nt, p, last, rd_cnt, stall, cyc, limit, h_row, h_col;
        bit seen, fin;
        logic [DW-1:0] h_data;
        of = of_sz(d); nt = ICS[d]*KS*KS;
        p = 0; last = 0; rd_cnt = 0; stall = 0; cyc = 0; seen = 0; fin = 0;
        h_row = 0; h_col = 0; h_data = '0; last_data = '0;
        limit = of*of*(nt+2)*4 + 100;
        @(negedge clk); start[d] = 1'b1;
        while (!fin && cyc < limit) begin
            @(negedge clk); cyc++;
            start[d] = 1'b0;
            if (cyc == 1) chk(tg("busy_on", d), busy[d], 1);
            if (rd_en[d]) begin
                rd_cnt++;
                if (int'(rd_addr[d]) >= ICS[d]*IFS[d]*IFS[d]) chk(tg("addr_range", d), rd_addr[d], 0);
            end
            if (valid[d]) begin
                if (!seen) begin
                    seen = 1;
                    chk(tg("latency", d), cyc - last, nt + 2);
                    chk(tg("row", d), orow[d], p / of);
                    chk(tg("col", d), ocol[d], p % of);
                    chk(tg("data", d), odata[d], ref_pix(d, p / of, p % of));
                    chk(tg("rd_count", d), rd_cnt, ref_taps(d, p / of, p % of));
                    h_data = odata[d]; h_row = int'(orow[d]); h_col = int'(ocol[d]);
                end else begin
                    chk(tg("hold", d), {rd_en[d], odata[d], orow[d], ocol[d]},
                        {1'b0, h_data, h_row[1:0], h_col[1:0]});
                end
                case (mode)
                    0:       ready[d] = 1'b1;
                    1:       ready[d] = ($urandom_range(0, 2) != 0);
                    default: ready[d] = !(p == 1 && stall < 5);
                endcase
                if (!ready[d]) stall++;
                else begin
                    last_data = h_data;
                    p++; last = cyc; rd_cnt = 0; seen = 0;
                end
            end
            if (done[d]) begin
                chk(tg("done_at", d), cyc - last, 1);
                chk(tg("n_pix", d), p, of*of);
                fin = 1;
            end
        end
        if (!fin) chk(tg("timeout", d), 0, 1);
        if (mode == 2) chk(tg("stall_len", d), stall, 5);
        ready[d] = 1'b1;
        @(negedge clk);
        chk(tg("back_idle", d), {busy[d], done[d], valid[d]}, 0);
    endtask

    task automatic reset_mid(input int d);
        int nt;
        nt = ICS[d]*KS*KS;
        ready[d] = 1'b1;
        @(negedge clk); start[d] = 1'b1;
        @(negedge clk); start[d] = 1'b0;
        repeat (3*(nt+2) + 4) @(negedge clk);
        chk(tg("pre_rst_state", d), {busy[d], valid[d], orow[d], ocol[d]}, {1'b1, 1'b0, 2'd1, 2'd0});
        reset = 1'b1;
        @(negedge clk);
        chk_idle(d, "mid_rst");
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic [DW-1:0] ld;
        reset = 1'b1;
        start = '{1'b0, 1'b0};
        ready = '{1'b1, 1'b1};
        wts   = '{default: '0};
        bias  = '{default: '0};
        load(0, 0, 0, 0, 0);
        load(1, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        chk_idle(0, "rst_state");
        chk_idle(1, "rst_state");
        reset = 1'b0;
        @(negedge clk);

        load(1, 1, 1, 1, 0);          run_frame(1, 0, ld); chk("ones_b", ld, 9);
        load(1, RNDS, RNDS, RNDS, RND); run_frame(1, 2, ld);
        load(0, 255, 255, 127, 0);    run_frame(0, 0, ld); chk("relu_hi", ld, 255);
        load(0, 255, 255, -1, 0);     run_frame(0, 0, ld); chk("relu_lo", ld, 0);
        load(1, 255, 255, -1, 0);     run_frame(1, 0, ld); chk("sat_lo", ld, 128);
        load(1, 255, 255, 127, 0);    run_frame(1, 0, ld); chk("sat_hi", ld, 127);
        load(0, 1, 3, 1, -10);        run_frame(0, 0, ld); chk("bias_shift", ld, 3);

        for (int k = 0; k < 3; k++) begin
            load(0, RNDS, RNDS, RNDS, RND); run_frame(0, 1, ld);
            load(0, RND, RND, RND, RND);     run_frame(0, 1, ld);
            load(1, RNDS, RNDS, RNDS, RND); run_frame(1, 1, ld);
            load(1, RND, RND, RND, RND);     run_frame(1, 1, ld);
        end

        load(0, RNDS, RNDS, RNDS, RND);
        reset_mid(0);
        run_frame(0, 0, ld);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
